// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with tear-free frame updates.
// Values are staged in a shadow register and moved to the display register only
// at frame boundaries. All outputs are registered and change only on slot ticks.
module seven_seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        value_load,
    input  logic [3:0]  dp_mask,
    input  logic        blank_en,
    input  logic        display_en,
    output logic [3:0]  hex,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned NIB_W = 4;

    // One complete frame's worth of display content
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp_mask;
        logic        blank_en;
    } frame_t;

    frame_t             shadow;
    frame_t             disp;
    frame_t             view_c;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt_c;
    logic               tick_c;
    logic               boundary_c;
    logic               blanked_c;
    logic [NIB_W-1:0]   hex_nxt_c;
    logic               dp_nxt_c;
    logic [3:0]         an_nxt_c;

    // Slot timing: tick on the last count of each slot, and detect frame start
    always_comb begin
        tick_c     = (cnt == CNT_W'(REFRESH_DIV - 1));
        idx_nxt_c  = idx + IDX_W'(1);
        boundary_c = tick_c && (idx_nxt_c == IDX_W'(0));
        // Digit 0 of a new frame must already see the freshly transferred shadow
        view_c     = boundary_c ? shadow : disp;
    end

    // Slot contents for the digit that becomes active on the coming tick
    always_comb begin
        blanked_c = 1'b0;
        case (idx_nxt_c)
            2'd1:    blanked_c = view_c.blank_en && (view_c.value[15:4]  == 12'h000);
            2'd2:    blanked_c = view_c.blank_en && (view_c.value[15:8]  == 8'h00);
            2'd3:    blanked_c = view_c.blank_en && (view_c.value[15:12] == 4'h0);
            default: blanked_c = 1'b0;
        endcase
        hex_nxt_c = view_c.value[{idx_nxt_c, 2'b00} +: NIB_W];
        dp_nxt_c  = blanked_c | ~view_c.dp_mask[idx_nxt_c];
        an_nxt_c  = 4'b1111;
        if (display_en && !blanked_c) begin
            an_nxt_c[idx_nxt_c] = 1'b0;
        end
    end

    // Slot counter, wrapping at the end of each digit slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow register captures new content whenever a load strobe arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
        end else if (value_load) begin
            shadow <= {value, dp_mask, blank_en};
        end
    end

    // Display register only changes at frame boundaries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp <= '0;
        end else if (boundary_c) begin
            disp <= shadow;
        end
    end

    // Digit index and registered outputs advance together on each tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= IDX_W'(3);
            hex <= 4'h0;
            dp  <= 1'b1;
            an  <= 4'b1111;
        end else if (tick_c) begin
            idx <= idx_nxt_c;
            hex <= hex_nxt_c;
            dp  <= dp_nxt_c;
            an  <= an_nxt_c;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Testbench for seven_seg_scan_driver: scenario tasks plus a randomized run,
// checked against a frame-level reference model.
module tb_seven_seg_scan_driver;

    localparam int unsigned REFRESH_DIV = 4;
    localparam int unsigned CNT_W       = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] value = 16'h0;
    logic        value_load = 1'b0;
    logic [3:0]  dp_mask = 4'h0;
    logic        blank_en = 1'b0;
    logic        display_en = 1'b1;
    logic [3:0]  hex;
    logic        dp;
    logic [3:0]  an;
    logic [8:0]  got;

    int tests = 0;
    int fails = 0;

    // Reference model state: edges since reset release, shadow, shown frame, outputs
    int          m_n;
    int          m_idx;
    bit          m_tick;
    logic [15:0] m_sv, m_dv;
    logic [3:0]  m_sd, m_dd;
    logic        m_sb, m_db;
    logic [8:0]  m_out;

    always #5 clk = ~clk;

    assign got = {an, dp, hex};

    seven_seg_scan_driver #(
        .REFRESH_DIV(REFRESH_DIV),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value     (value),
        .value_load(value_load),
        .dp_mask   (dp_mask),
        .blank_en  (blank_en),
        .display_en(display_en),
        .hex       (hex),
        .dp        (dp),
        .an        (an)
    );

    // What digit k of a frame should look like: {an, dp, hex}
    function automatic logic [8:0] slot_out(int k, logic [15:0] v, logic [3:0] dpm,
                                            logic bl, logic en);
        int unsigned upper;
        logic [3:0]  nib;
        logic        blanked;
        logic [3:0]  a;
        logic        d;
        upper   = 32'(v) >> (4 * k);
        nib     = 4'(upper % 16);
        blanked = bl && (k > 0) && (upper == 0);
        a       = (!en || blanked) ? 4'hF : 4'(~(32'd1 << k));
        d       = blanked ? 1'b1 : ~dpm[k];
        return {a, d, nib};
    endfunction

    task automatic model_reset();
        m_n = 0; m_idx = 3; m_tick = 0;
        m_sv = '0; m_sd = '0; m_sb = 1'b0;
        m_dv = '0; m_dd = '0; m_db = 1'b0;
        m_out = 9'h1F0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        int n;
        n = m_n + 1;
        m_tick = (n % 4 == 0);
        if (m_tick) begin
            m_idx = ((n / 4) - 1) % 4;
            if (m_idx == 0) begin
                m_dv = m_sv; m_dd = m_sd; m_db = m_sb;
            end
            m_out = slot_out(m_idx, m_dv, m_dd, m_db, display_en);
        end
        if (value_load) begin
            m_sv = value; m_sd = dp_mask; m_sb = blank_en;
        end
        m_n = n;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] dpm, input logic bl);
        value = v; dp_mask = dpm; blank_en = bl; value_load = 1'b1;
        step();
        value_load = 1'b0;
    endtask

    // Step until the tick that selects digit k (bounded)
    task automatic run_to(input int k, output bit ok);
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (m_tick && m_idx == k) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (got !== 9'h1F0) begin
            fails++;
            $display("FAIL reset_state: got an=%b dp=%b hex=%h, want an=1111 dp=1 hex=0", an, dp, hex);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_idle();
        logic [3:0] an_tab [4];
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 40; i++) begin
            step();
            tests++;
            if (got !== m_out) begin
                fails++;
                $display("FAIL idle_model cyc %0d: got %b want %b", i, got, m_out);
            end
            if (i < 3 || m_tick) begin
                tests++;
                if (an !== ((i < 3) ? 4'hF : an_tab[m_idx]) || hex !== 4'h0 || dp !== 1'b1) begin
                    fails++;
                    $display("FAIL idle_scan cyc %0d: got an=%b dp=%b hex=%h", i, an, dp, hex);
                end
            end
        end
    endtask

    task automatic test_load_pattern();
        bit ok;
        logic [3:0] hex_tab [4];
        hex_tab = '{4'hF, 4'hA, 4'h2, 4'h1};
        pulse_load(16'h12AF, 4'b0100, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_to(k, ok);
            tests++;
            if (!ok || hex !== hex_tab[k] || dp !== (k != 2) || an !== 4'(~(32'd1 << k))) begin
                fails++;
                $display("FAIL pattern digit %0d: got an=%b dp=%b hex=%h want hex=%h dp=%0d",
                         k, an, dp, hex, hex_tab[k], (k != 2));
            end
        end
    endtask

    task automatic test_blanking();
        bit ok;
        pulse_load(16'h0005, 4'b0000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_to(k, ok);
            tests++;
            if (!ok || an !== ((k == 0) ? 4'b1110 : 4'b1111) || dp !== 1'b1 ||
                (k == 0 && hex !== 4'h5)) begin
                fails++;
                $display("FAIL blank_0005 digit %0d: got an=%b dp=%b hex=%h", k, an, dp, hex);
            end
        end
        pulse_load(16'h0105, 4'b0000, 1'b1);
        run_to(0, ok);
        for (int k = 1; k < 4; k++) begin
            run_to(k, ok);
            tests++;
            if (!ok || an !== ((k == 3) ? 4'b1111 : 4'(~(32'd1 << k))) ||
                hex !== ((k == 2) ? 4'h1 : 4'h0)) begin
                fails++;
                $display("FAIL blank_0105 digit %0d: got an=%b hex=%h", k, an, hex);
            end
        end
    endtask

    task automatic test_mid_frame_load();
        bit ok;
        pulse_load(16'hAAAA, 4'b0000, 1'b0);
        run_to(0, ok);
        run_to(2, ok);
        pulse_load(16'h5555, 4'b0000, 1'b0);
        run_to(3, ok);
        tests++;
        if (!ok || hex !== 4'hA || an !== 4'b0111) begin
            fails++;
            $display("FAIL midframe_digit3: got an=%b hex=%h want an=0111 hex=a", an, hex);
        end
        for (int k = 0; k < 4; k++) begin
            run_to(k, ok);
            tests++;
            if (!ok || hex !== 4'h5) begin
                fails++;
                $display("FAIL midframe_next digit %0d: got hex=%h want 5", k, hex);
            end
        end
    endtask

    task automatic test_boundary_load();
        bit ok;
        bit found;
        pulse_load(16'hAAAA, 4'b0000, 1'b0);
        run_to(0, ok);
        found = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_n % 16 == 3) begin
                found = 1;
                break;
            end
            step();
        end
        pulse_load(16'h5555, 4'b0000, 1'b0);
        tests++;
        if (!found || hex !== 4'hA || an !== 4'b1110) begin
            fails++;
            $display("FAIL boundary_load_same_frame: got an=%b hex=%h want an=1110 hex=a", an, hex);
        end
        run_to(0, ok);
        tests++;
        if (!ok || hex !== 4'h5 || an !== 4'b1110) begin
            fails++;
            $display("FAIL boundary_load_next_frame: got an=%b hex=%h want an=1110 hex=5", an, hex);
        end
    endtask

    task automatic test_display_en();
        bit ok;
        pulse_load(16'h4321, 4'b0000, 1'b0);
        run_to(0, ok);
        run_to(3, ok);
        display_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            run_to(k, ok);
            tests++;
            if (!ok || an !== 4'hF || hex !== 4'(k + 1)) begin
                fails++;
                $display("FAIL disp_off digit %0d: got an=%b hex=%h want an=1111 hex=%0d",
                         k, an, hex, k + 1);
            end
        end
        display_en = 1'b1;
        run_to(0, ok);
        tests++;
        if (!ok || an !== 4'b1110 || hex !== 4'h1) begin
            fails++;
            $display("FAIL disp_restore: got an=%b hex=%h want an=1110 hex=1", an, hex);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        pulse_load(16'h1234, 4'b1111, 1'b0);
        run_to(0, ok);
        run_to(2, ok);
        step();
        #2 reset = 1'b1;
        #1;
        tests++;
        if (got !== 9'h1F0) begin
            fails++;
            $display("FAIL reset_mid_immediate: got an=%b dp=%b hex=%h", an, dp, hex);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (got !== ((i < 3) ? 9'h1F0 : 9'b1110_1_0000)) begin
                fails++;
                $display("FAIL reset_mid_after cyc %0d: got an=%b dp=%b hex=%h", i, an, dp, hex);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        for (int i = 0; i < 600; i++) begin
            value_load = 1'b0;
            if ($urandom_range(7) == 0) begin
                for (int j = 0; j < 4; j++) begin
                    v[4*j +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
                end
                value = v;
                dp_mask = 4'($urandom_range(15));
                blank_en = 1'($urandom_range(1));
                value_load = 1'b1;
            end
            if ($urandom_range(15) == 0) display_en = ~display_en;
            step();
            tests++;
            if (got !== m_out) begin
                fails++;
                $display("FAIL random cyc %0d: got an=%b dp=%b hex=%h want %b", i, an, dp, hex, m_out);
            end
        end
        value_load = 1'b0;
        display_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_pattern();
        test_blanking();
        test_mid_frame_load();
        test_boundary_load();
        test_display_en();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
